// File: rtl/reg_access_arbiter_pkg.sv
// Shared widths and FSM state encoding for the two-requester register-file arbiter.
package reg_access_arbiter_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Bundle of requester and register-file signals shared by the arbiter and its environment.
interface reg_access_arbiter_if;
    import reg_access_arbiter_pkg::*;

    logic              m0_req;
    logic              m1_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic              m0_r_wn;
    logic              m1_r_wn;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_ack;
    logic              m1_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_r_wn;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              busy;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_r_wn, m1_r_wn,
        input  m0_wdata, m1_wdata, rf_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output rf_addr, rf_r_wn, rf_wdata, busy
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_r_wn, m1_r_wn,
        output m0_wdata, m1_wdata, rf_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  rf_addr, rf_r_wn, rf_wdata, busy
    );

endinterface

// File: rtl/reg_access_arbiter_rr_arb2.sv
// Two-input round-robin grant with a "last granted" pointer; m1 is treated as last after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_m1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_m1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // The pointer only moves when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_m1 <= 1'b1;
        end else if (grant_en && (req != 2'b00)) begin
            last_m1 <= grant[1];
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Serialises two requesters onto one register-file port: latch winner, issue, wait for read data, ack.
module reg_access_arbiter
    import reg_access_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_access_arbiter_if.slave  bus
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              grant_en;
    logic              capture;
    logic              win_m1;
    logic              lat_r_wn;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign req = {bus.m1_req, bus.m0_req};

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_en   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = lat_r_wn ? WAIT : ACK;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Winner fields are latched once in IDLE so later requester changes are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_m1   <= 1'b0;
            lat_r_wn <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (grant_en) begin
            win_m1   <= (grant == 2'b10);
            lat_r_wn <= (grant == 2'b10) ? bus.m1_r_wn  : bus.m0_r_wn;
            addr_q   <= (grant == 2'b10) ? bus.m1_addr  : bus.m0_addr;
            wdata_q  <= (grant == 2'b10) ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 2'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (capture) begin
            if (win_m1) begin
                rdata1_q <= bus.rf_rdata;
            end else begin
                rdata0_q <= bus.rf_rdata;
            end
        end
    end

    // The write strobe is a pure decode of the ISSUE cycle, so reset drops it immediately.
    assign bus.rf_r_wn  = !((state == ISSUE) && !lat_r_wn);
    assign bus.rf_addr  = addr_q;
    assign bus.rf_wdata = wdata_q;
    assign bus.m0_ack   = (state == ACK) && !win_m1;
    assign bus.m1_ack   = (state == ACK) && win_m1;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench: one arbiter with RD_LATENCY 1, one with RD_LATENCY 3.
module tb_reg_access_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_access_arbiter_if bus_a ();
    reg_access_arbiter_if bus_b ();

    reg_access_arbiter #(.RD_LATENCY(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    reg_access_arbiter #(.RD_LATENCY(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    int          w_ack_cyc;
    int          w_who;
    int          w_strobes;
    logic [10:0] w_strobe_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata0;
    logic [31:0] w_rdata1;
    logic        w_busy1;
    logic        w_both;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit who, input logic req,
                                 input logic r_wn, input logic [10:0] addr, input logic [31:0] wdata);
        if (!sel && !who) begin
            bus_a.m0_req = req; bus_a.m0_r_wn = r_wn; bus_a.m0_addr = addr; bus_a.m0_wdata = wdata;
        end else if (!sel && who) begin
            bus_a.m1_req = req; bus_a.m1_r_wn = r_wn; bus_a.m1_addr = addr; bus_a.m1_wdata = wdata;
        end else if (sel && !who) begin
            bus_b.m0_req = req; bus_b.m0_r_wn = r_wn; bus_b.m0_addr = addr; bus_b.m0_wdata = wdata;
        end else begin
            bus_b.m1_req = req; bus_b.m1_r_wn = r_wn; bus_b.m1_addr = addr; bus_b.m1_wdata = wdata;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Step up to max_cyc cycles, recording strobes and the first ack; cycle 1 follows the first edge.
    task automatic watch(input bit sel, input int max_cyc, input bit drop);
        logic        a0, a1, rwn, bz;
        logic [10:0] ad;
        logic [31:0] wd, r0, r1;
        w_ack_cyc = 0; w_who = -1; w_strobes = 0; w_strobe_addr = '0;
        w_wdata = '0; w_rdata0 = '0; w_rdata1 = '0; w_busy1 = 1'b0; w_both = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (sel) begin
                a0 = bus_b.m0_ack; a1 = bus_b.m1_ack; rwn = bus_b.rf_r_wn; bz = bus_b.busy;
                ad = bus_b.rf_addr; wd = bus_b.rf_wdata; r0 = bus_b.m0_rdata; r1 = bus_b.m1_rdata;
            end else begin
                a0 = bus_a.m0_ack; a1 = bus_a.m1_ack; rwn = bus_a.rf_r_wn; bz = bus_a.busy;
                ad = bus_a.rf_addr; wd = bus_a.rf_wdata; r0 = bus_a.m0_rdata; r1 = bus_a.m1_rdata;
            end
            if (c == 1) w_busy1 = bz;
            if (!rwn) begin
                w_strobes++;
                w_strobe_addr = ad;
            end
            if (a0 || a1) begin
                w_ack_cyc = c;
                w_who     = a1 ? 1 : 0;
                w_both    = a0 && a1;
                w_wdata   = wd;
                w_rdata0  = r0;
                w_rdata1  = r1;
                if (drop) begin
                    if (sel) begin
                        if (a1) bus_b.m1_req = 1'b0; else bus_b.m0_req = 1'b0;
                    end else begin
                        if (a1) bus_a.m1_req = 1'b0; else bus_a.m0_req = 1'b0;
                    end
                end
                break;
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst_n = 1'b0;
        applyStimulus(0, 0, 0, 1, '0, '0); applyStimulus(0, 1, 0, 1, '0, '0);
        applyStimulus(1, 0, 0, 1, '0, '0); applyStimulus(1, 1, 0, 1, '0, '0);
        bus_a.rf_rdata = '0; bus_b.rf_rdata = '0;
        #12 rst_n = 1'b1;
        idleCycles(1);

        checkOutput("rst_busy",    32'(bus_a.busy),     32'd0);
        checkOutput("rst_m0_ack",  32'(bus_a.m0_ack),   32'd0);
        checkOutput("rst_m1_ack",  32'(bus_a.m1_ack),   32'd0);
        checkOutput("rst_m0_rdata", bus_a.m0_rdata,     32'd0);
        checkOutput("rst_rf_r_wn", 32'(bus_a.rf_r_wn),  32'd1);
        checkOutput("rst_rf_addr", 32'(bus_a.rf_addr),  32'd0);

        // m0 write: one strobe at 0x010, ack in cycle 2, m1 never acked
        applyStimulus(0, 0, 1, 0, 11'h010, 32'hDEADBEEF);
        watch(0, 8, 1);
        checkOutput("wr_ack_cyc",    32'(w_ack_cyc),     32'd2);
        checkOutput("wr_who",        32'(w_who),         32'd0);
        checkOutput("wr_both",       32'(w_both),        32'd0);
        checkOutput("wr_strobes",    32'(w_strobes),     32'd1);
        checkOutput("wr_strobe_addr", 32'(w_strobe_addr), 32'h010);
        checkOutput("wr_wdata",      w_wdata,            32'hDEADBEEF);
        checkOutput("wr_rdata_keep", w_rdata0,           32'd0);
        watch(0, 4, 1);
        checkOutput("wr_no_more_ack", 32'(w_ack_cyc),    32'd0);
        checkOutput("wr_no_more_stb", 32'(w_strobes),    32'd0);

        // m0 read then m1 read; each lands only in its own rdata
        bus_a.rf_rdata = 32'hA5A50001;
        applyStimulus(0, 0, 1, 1, 11'h020, 32'h0);
        watch(0, 8, 1);
        checkOutput("rd0_ack_cyc", 32'(w_ack_cyc), 32'd3);
        checkOutput("rd0_who",     32'(w_who),     32'd0);
        checkOutput("rd0_rdata",   w_rdata0,       32'hA5A50001);
        checkOutput("rd0_strobes", 32'(w_strobes), 32'd0);
        idleCycles(1);
        bus_a.rf_rdata = 32'h12345678;
        applyStimulus(0, 1, 1, 1, 11'h004, 32'h0);
        watch(0, 8, 1);
        checkOutput("rd1_ack_cyc",  32'(w_ack_cyc), 32'd3);
        checkOutput("rd1_who",      32'(w_who),     32'd1);
        checkOutput("rd1_rdata",    w_rdata1,       32'h12345678);
        checkOutput("rd1_m0_keep",  w_rdata0,       32'hA5A50001);
        idleCycles(1);

        // reset asserted during WAIT of a read
        bus_a.rf_rdata = 32'hFFFF0000;
        applyStimulus(0, 0, 1, 1, 11'h030, 32'h0);
        idleCycles(2);
        checkOutput("mid_busy_before", 32'(bus_a.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy",     32'(bus_a.busy),     32'd0);
        checkOutput("mid_m0_ack",   32'(bus_a.m0_ack),   32'd0);
        checkOutput("mid_rf_r_wn",  32'(bus_a.rf_r_wn),  32'd1);
        checkOutput("mid_m0_rdata", bus_a.m0_rdata,      32'd0);
        checkOutput("mid_m1_rdata", bus_a.m1_rdata,      32'd0);
        checkOutput("mid_rf_addr",  32'(bus_a.rf_addr),  32'd0);
        applyStimulus(0, 0, 0, 1, 11'h030, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        watch(0, 5, 1);
        checkOutput("mid_no_ack",   32'(w_ack_cyc), 32'd0);

        // contention held continuously: m0, m1, m0, m1
        applyStimulus(0, 0, 1, 0, 11'h100, 32'h0000_0001);
        applyStimulus(0, 1, 1, 0, 11'h200, 32'h0000_0002);
        watch(0, 8, 0);
        checkOutput("rr1_who",  32'(w_who),         32'd0);
        checkOutput("rr1_cyc",  32'(w_ack_cyc),     32'd2);
        checkOutput("rr1_addr", 32'(w_strobe_addr), 32'h100);
        watch(0, 8, 0);
        checkOutput("rr2_who",  32'(w_who),         32'd1);
        checkOutput("rr2_cyc",  32'(w_ack_cyc),     32'd3);
        checkOutput("rr2_addr", 32'(w_strobe_addr), 32'h200);
        checkOutput("rr2_wdata", w_wdata,           32'h0000_0002);
        watch(0, 8, 0);
        checkOutput("rr3_who",  32'(w_who),         32'd0);
        watch(0, 8, 0);
        checkOutput("rr4_who",  32'(w_who),         32'd1);
        checkOutput("rr4_both", 32'(w_both),        32'd0);
        applyStimulus(0, 0, 0, 1, '0, '0);
        applyStimulus(0, 1, 0, 1, '0, '0);
        idleCycles(2);

        // RD_LATENCY 3 read from m1
        bus_b.rf_rdata = 32'hCAFE_F00D;
        applyStimulus(1, 1, 1, 1, 11'h7FF, 32'h0);
        watch(1, 10, 1);
        checkOutput("l3_ack_cyc", 32'(w_ack_cyc), 32'd5);
        checkOutput("l3_who",     32'(w_who),     32'd1);
        checkOutput("l3_rdata",   w_rdata1,       32'hCAFE_F00D);
        checkOutput("l3_m0_keep", w_rdata0,       32'd0);
        idleCycles(1);

        // back-to-back m0 writes with req held: one strobe per ack, IDLE in between
        applyStimulus(1, 0, 1, 0, 11'h055, 32'h1111_2222);
        watch(1, 8, 0);
        checkOutput("b2b1_cyc",     32'(w_ack_cyc), 32'd2);
        checkOutput("b2b1_strobes", 32'(w_strobes), 32'd1);
        checkOutput("b2b1_rdata",   w_rdata0,       32'd0);
        for (int k = 0; k < 2; k++) begin
            watch(1, 8, 0);
            checkOutput($sformatf("b2b%0d_idle", k + 2),    32'(w_busy1),   32'd0);
            checkOutput($sformatf("b2b%0d_cyc", k + 2),     32'(w_ack_cyc), 32'd3);
            checkOutput($sformatf("b2b%0d_strobes", k + 2), 32'(w_strobes), 32'd1);
            checkOutput($sformatf("b2b%0d_who", k + 2),     32'(w_who),     32'd0);
        end
        applyStimulus(1, 0, 0, 1, '0, '0);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning register-file read latency in clk cycles (1..4).
REQ-002 SHALL have port clk  input  1  master clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset-not; asynchronous assert, active-low.
REQ-004 SHALL have ports m0_req / m1_req  input  1  each  requester access request.
REQ-005 SHALL have ports m0_addr / m1_addr  input  11 each  requester register address.
REQ-006 SHALL have ports m0_r_wn / m1_r_wn  input  1 each  1 = read, 0 = write.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  32 each  requester write data.
REQ-008 SHALL have ports m0_ack / m1_ack  output  1 each  single-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata / m1_rdata  output  32 each  read data, valid when ack is high.
REQ-010 SHALL have ports rf_addr  output  11, rf_r_wn  output  1, rf_wdata  output  32  to the register file.
REQ-011 SHALL have port rf_rdata  input  32  register-file read data.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL arbitrate the two requesters onto the single register-file port, one transaction at a time.
REQ-014 SHALL hold rf_r_wn = 1 in every cycle except the single ISSUE cycle of a write, so that exactly one write strobe is produced per write transaction.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT and ACK.
REQ-016 SHALL move IDLE->ISSUE on any sampled req and latch the winner's addr, r_wn and wdata.
REQ-017 SHALL move ISSUE->ACK for a write, and ISSUE->WAIT for a read.
REQ-018 SHALL stay in WAIT for RD_LATENCY cycles, then capture rf_rdata into the winner's rdata register and move to ACK.
REQ-019 SHALL assert only the winner's ack for exactly one cycle in ACK, then return to IDLE.
REQ-020 SHALL have latency, counted from the edge sampling req in IDLE: write ack in cycle 2; read ack in cycle 2+RD_LATENCY.
REQ-021 SHALL hold rf_addr and rf_wdata stable from ISSUE through ACK.
REQ-022 SHALL use round-robin on simultaneous requests: grant goes to the requester not granted last.
REQ-023 SHALL grant a lone requester regardless of the round-robin pointer.
REQ-024 SHALL update the round-robin pointer only on grant.
REQ-025 SHALL ignore req while not in IDLE.
REQ-026 SHALL require requesters to hold req and their fields stable until ack; changes made before ack are not observed.
REQ-027 SHALL treat req still high in the cycle after ack as a new request.
REQ-028 SHALL hold the loser's request, unacknowledged, and grant it on the next IDLE.
REQ-029 SHALL leave the non-winner's rdata unchanged.
REQ-030 SHALL not update rdata on a write.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-transaction, immediately force state = IDLE, busy = 0, acks = 0, m0_rdata = m1_rdata = 0, rf_addr = 0, rf_wdata = 0, rf_r_wn = 1, and pointer = "m1 last", so m0 wins the first contention.
REQ-032 SHALL abandon a transaction interrupted by reset with no ack and no further write strobe.

Structure
REQ-033 SHALL place the state encoding, ADDR_W = 11 and DATA_W = 32 in a shared package.
REQ-034 SHALL implement the two-input round-robin grant logic and pointer as sub-module rr_arb2.

Verification
REQ-035 SHALL cover: m0 write addr 0x010 data 0xDEADBEEF -> rf_r_wn low for exactly one cycle with rf_addr 0x010; m0_ack at cycle 2; m1_ack never asserted.
REQ-036 SHALL cover: m1 read addr 0x004 with rf_rdata = 0x12345678, RD_LATENCY 1 -> m1_ack at cycle 3 with m1_rdata = 0x12345678; m0_rdata unchanged.
REQ-037 SHALL cover: both requesters high together after reset -> m0 served first, then m1; with both held continuously, grants alternate m0, m1, m0, m1.
REQ-038 SHALL cover: rst_n low during WAIT of a read -> all outputs at reset values within the same cycle; no ack; rf_r_wn = 1.
REQ-039 SHALL cover: RD_LATENCY = 3 read -> ack at cycle 5; back-to-back writes from m0 -> one write strobe per ack, with an IDLE cycle between transactions.
